bin2bcd_digit_scanner: RTL

Upstream stage for the BCD-to-7-segment decoder on the multi-digit display board. It accepts a binary value over a valid/ready handshake and converts it to packed BCD using an iterative double-dabble FSM. It then time-multiplexes the digits, presenting one 4-bit BCD code plus a one-hot digit select per scan slot. The bcd_out port feeds the decoder's bcd input directly; codes 10-15 decode to blank, and this block uses 4'hF as its blank code.

---
 rtl/bcd_disp_pkg.sv | 25 ++
 rtl/bin2bcd_dd.sv | 94 +++++++++
 rtl/bin2bcd_digit_scanner.sv | 92 +++++++++
 3 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and constants for the binary-to-BCD display scanner.
// Latency: none (package only).
// Backpressure: n/a.
package bcd_disp_pkg;

    // Code the downstream 7-segment decoder renders as an unlit digit.
    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } dd_state_t;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_val(input int unsigned digits);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return p - 1;
    endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// Iterative double-dabble converter: binary word in, packed BCD nibbles out.
// Latency: accept edge, then BIN_W shift cycles, then one COMMIT cycle with done high.
// Backpressure: in_ready only while IDLE; in_valid during CONV/COMMIT is ignored.
module bin2bcd_dd
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_W-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  range_err
);

    localparam int          BCD_W = 4 * DIGITS;
    localparam int          SR_W  = BCD_W + BIN_W;
    localparam int          CW    = $clog2(BIN_W + 1);
    localparam logic [31:0] MAX_V = max_val(DIGITS);

    dd_state_t          state;
    dd_state_t          state_nxt;
    logic [SR_W-1:0]    sr;
    logic [SR_W-1:0]    sr_adj;
    logic [CW-1:0]      cnt;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus handshake and done strobes.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                // cnt==1 means this cycle performs the last shift.
                if (cnt == CW'(1)) begin
                    state_nxt = COMMIT;
                end
            end
            COMMIT: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    always_comb begin
        sr_adj = sr;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift register, bit counter and out-of-range flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            cnt       <= '0;
            range_err <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            sr        <= {{BCD_W{1'b0}}, in_data};
            cnt       <= CW'(BIN_W);
            range_err <= (32'(in_data) > MAX_V);
        end else if (state == CONV) begin
            sr  <= {sr_adj[SR_W-2:0], 1'b0};
            cnt <= cnt - CW'(1);
        end
    end

    assign bcd = sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/bin2bcd_digit_scanner.sv
// Converts a binary value to BCD and time-multiplexes the digits onto one BCD bus.
// Latency: display updates BIN_W+1 cycles after the accept edge; outputs follow registered state.
// Backpressure: in_ready low for BIN_W+1 cycles per value; scanning never stalls.
module bin2bcd_digit_scanner
    import bcd_disp_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int LZB      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BIN_W-1:0]    in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                conv_done,
    output logic                ovf,
    output logic [3:0]          bcd_out,
    output logic [DIGITS-1:0]   digit_sel
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] conv_bcd;
    logic                conv_range;
    logic [4*DIGITS-1:0] display;
    logic [PW-1:0]       pres;
    logic [IW-1:0]       idx;
    logic                tick;
    logic [DIGITS-1:0]   blank;
    logic                upper_zero;

    bin2bcd_dd #(
        .BIN_W  (BIN_W),
        .DIGITS (DIGITS)
    ) u_dd (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .done      (conv_done),
        .bcd       (conv_bcd),
        .range_err (conv_range)
    );

    // Display register and overflow flag load together on the commit strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            display <= '0;
            ovf     <= 1'b0;
        end else if (conv_done) begin
            display <= conv_bcd;
            ovf     <= conv_range;
        end
    end

    assign tick = (pres == PW'(SCAN_DIV - 1));

    // Free-running slot prescaler and scan index, independent of conversion.
    always_ff @(posedge clk) begin
        if (rst) begin
            pres <= '0;
            idx  <= '0;
        end else if (tick) begin
            pres <= '0;
            idx  <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
        end else begin
            pres <= pres + PW'(1);
        end
    end

    // Blank mask: overflow hides all digits; leading zeros above digit 0 are hidden.
    always_comb begin
        blank      = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero = upper_zero && (display[4*i +: 4] == 4'd0);
            blank[i]   = ovf || ((LZB != 0) && (i > 0) && upper_zero);
        end
    end

    // Drive the select and code for the slot currently being scanned.
    always_comb begin
        digit_sel      = '0;
        digit_sel[idx] = 1'b1;
        bcd_out        = blank[idx] ? BLANK_CODE : display[4*idx +: 4];
    end

endmodule
